// File: rtl/reorder_buffer_if.sv
// Rename/CDB/commit signal bundle for the reorder buffer.
// The slave side is the ROB. The master side is the rename stage, the CDB and the commit consumer.
interface reorder_buffer_if #(
    parameter int REG   = 4,
    parameter int ROB   = 2,
    parameter int WIDTH = 31
) ();
    logic           allocValid;
    logic [REG:0]   allocDestReg;
    logic           allocRegWrite;
    logic [ROB:0]   destROB;
    logic           full;
    logic           empty;

    logic           cdbValid;
    logic [ROB:0]   cdbROB;
    logic [WIDTH:0] cdbResult;
    logic           cdbMispredict;
    logic [WIDTH:0] cdbTarget;

    logic           validCommit;
    logic [ROB:0]   commitROB;
    logic [REG:0]   regCommit;
    logic           commitRegWrite;
    logic [WIDTH:0] commitValue;
    logic           reset;
    logic [WIDTH:0] redirectPC;

    modport master (
        output allocValid, allocDestReg, allocRegWrite,
        output cdbValid, cdbROB, cdbResult, cdbMispredict, cdbTarget,
        input  destROB, full, empty,
        input  validCommit, commitROB, regCommit, commitRegWrite, commitValue, reset, redirectPC
    );

    modport slave (
        input  allocValid, allocDestReg, allocRegWrite,
        input  cdbValid, cdbROB, cdbResult, cdbMispredict, cdbTarget,
        output destROB, full, empty,
        output validCommit, commitROB, regCommit, commitRegWrite, commitValue, reset, redirectPC
    );
endinterface

// File: rtl/reorder_buffer.sv
// Circular reorder buffer: allocates tags at the tail, collects CDB results and retires in order
// from the head. A mispredicted head flushes the whole buffer as it commits.
module reorder_buffer #(
    parameter int REG   = 4,
    parameter int ROB   = 2,
    parameter int WIDTH = 31
) (
    input logic             clk,
    input logic             globalReset,
    reorder_buffer_if.slave rob
);
    localparam int Depth = 2 ** (ROB + 1);
    localparam logic [ROB+1:0] CountFull = (ROB + 2)'(Depth);
    localparam logic [ROB+1:0] CountOne  = (ROB + 2)'(1);
    localparam logic [ROB:0]   TagOne    = (ROB + 1)'(1);

    logic [Depth-1:0] valid_q;
    logic [Depth-1:0] ready_q;
    logic [Depth-1:0] mispredict_q;
    logic [Depth-1:0] regwrite_q;
    logic [REG:0]     dest_reg_q [Depth];
    logic [WIDTH:0]   value_q    [Depth];
    logic [WIDTH:0]   target_q   [Depth];

    logic [ROB:0]   head_q;
    logic [ROB:0]   tail_q;
    logic [ROB+1:0] count_q;
    logic [ROB+1:0] count_d;

    logic full;
    logic alloc_accept;
    logic wb_accept;
    logic commit;
    logic flush;

    // full is decoded from the registered count, so a same-cycle commit never frees a slot early
    assign full         = (count_q == CountFull);
    assign alloc_accept = rob.allocValid & ~full;
    assign wb_accept    = rob.cdbValid & valid_q[rob.cdbROB];
    assign commit       = valid_q[head_q] & ready_q[head_q];
    assign flush        = commit & mispredict_q[head_q];

    assign rob.full           = full;
    assign rob.empty          = (count_q == '0);
    assign rob.destROB        = tail_q;
    assign rob.validCommit    = commit;
    assign rob.commitROB      = head_q;
    assign rob.regCommit      = dest_reg_q[head_q];
    assign rob.commitRegWrite = regwrite_q[head_q];
    assign rob.commitValue    = value_q[head_q];
    assign rob.reset          = flush;
    assign rob.redirectPC     = target_q[head_q];

    always_comb begin
        count_d = count_q;
        if (alloc_accept && !commit) begin
            count_d = count_q + CountOne;
        end else if (!alloc_accept && commit) begin
            count_d = count_q - CountOne;
        end
    end

    always_ff @(posedge clk) begin
        if (!globalReset) begin
            head_q       <= '0;
            tail_q       <= '0;
            count_q      <= '0;
            valid_q      <= '0;
            ready_q      <= '0;
            mispredict_q <= '0;
            regwrite_q   <= '0;
            for (int i = 0; i < Depth; i++) begin
                dest_reg_q[i] <= '0;
                value_q[i]    <= '0;
                target_q[i]   <= '0;
            end
        end else if (flush) begin
            // Same-cycle allocation and CDB write are dropped along with everything younger
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            valid_q <= '0;
            ready_q <= '0;
        end else begin
            count_q <= count_d;
            if (alloc_accept) begin
                valid_q[tail_q]      <= 1'b1;
                ready_q[tail_q]      <= 1'b0;
                mispredict_q[tail_q] <= 1'b0;
                regwrite_q[tail_q]   <= rob.allocRegWrite;
                dest_reg_q[tail_q]   <= rob.allocDestReg;
                tail_q               <= tail_q + TagOne;
            end
            if (wb_accept) begin
                ready_q[rob.cdbROB]      <= 1'b1;
                mispredict_q[rob.cdbROB] <= rob.cdbMispredict;
                value_q[rob.cdbROB]      <= rob.cdbResult;
                target_q[rob.cdbROB]     <= rob.cdbTarget;
            end
            if (commit) begin
                valid_q[head_q] <= 1'b0;
                head_q          <= head_q + TagOne;
            end
        end
    end
endmodule

// File: tb/tb_reorder_buffer.sv
// Directed bench for reorder_buffer: fill/full, out-of-order writeback, alloc+commit overlap,
// pointer wrap, mispredict flush and reset during a flush.
module tb_reorder_buffer;
    logic clk = 1'b0;
    logic globalReset;
    int   total = 0;
    int   bad   = 0;

    reorder_buffer_if #(.REG(4), .ROB(2), .WIDTH(31)) bus ();

    reorder_buffer #(.REG(4), .ROB(2), .WIDTH(31)) u_dut (
        .clk        (clk),
        .globalReset(globalReset),
        .rob        (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.allocValid    = 1'b0;
        bus.allocDestReg  = '0;
        bus.allocRegWrite = 1'b0;
        bus.cdbValid      = 1'b0;
        bus.cdbROB        = '0;
        bus.cdbResult     = '0;
        bus.cdbMispredict = 1'b0;
        bus.cdbTarget     = '0;
    endtask

    task automatic cdb(input logic [2:0] tag, input logic [31:0] val);
        bus.cdbValid      = 1'b1;
        bus.cdbROB        = tag;
        bus.cdbResult     = val;
        bus.cdbMispredict = 1'b0;
        bus.cdbTarget     = '0;
    endtask

    initial begin
        idle();
        globalReset = 1'b0;
        tick();
        tick();
        globalReset = 1'b1;

        // Reset state
        check("rst_empty", bus.empty, 1);
        check("rst_full", bus.full, 0);
        check("rst_destROB", bus.destROB, 0);
        check("rst_validCommit", bus.validCommit, 0);
        check("rst_reset", bus.reset, 0);
        check("rst_commitROB", bus.commitROB, 0);
        check("rst_regCommit", bus.regCommit, 0);
        check("rst_commitValue", bus.commitValue, 0);
        check("rst_redirectPC", bus.redirectPC, 0);

        // Fill 8 entries, regs x1..x8
        for (int i = 0; i < 8; i++) begin
            bus.allocValid    = 1'b1;
            bus.allocDestReg  = 5'(i + 1);
            bus.allocRegWrite = 1'b1;
            check($sformatf("fill_destROB_%0d", i), bus.destROB, 32'(i));
            check($sformatf("fill_notfull_%0d", i), bus.full, 0);
            tick();
        end
        check("fill_full", bus.full, 1);
        check("fill_notempty", bus.empty, 0);
        bus.allocDestReg = 5'd9;
        check("ninth_destROB", bus.destROB, 0);
        tick();
        idle();
        check("ninth_still_full", bus.full, 1);
        check("ninth_destROB_after", bus.destROB, 0);
        check("ninth_no_commit", bus.validCommit, 0);

        // Out-of-order writeback 2, 0, 1
        cdb(3'd2, 32'h22);
        check("ooo_no_commit_a", bus.validCommit, 0);
        tick();
        cdb(3'd0, 32'h00);
        check("ooo_no_commit_b", bus.validCommit, 0);
        tick();
        // Commit of tag 0 while full: the concurrent allocation must be refused
        cdb(3'd1, 32'h11);
        bus.allocValid    = 1'b1;
        bus.allocDestReg  = 5'd9;
        bus.allocRegWrite = 1'b1;
        check("ooo_c0_valid", bus.validCommit, 1);
        check("ooo_c0_rob", bus.commitROB, 0);
        check("ooo_c0_reg", bus.regCommit, 1);
        check("ooo_c0_regwrite", bus.commitRegWrite, 1);
        check("ooo_c0_value", bus.commitValue, 0);
        check("ooo_c0_reset", bus.reset, 0);
        check("ooo_c0_full", bus.full, 1);
        tick();
        idle();
        check("full_commit_no_bypass", bus.destROB, 0);
        check("ooo_c1_full", bus.full, 0);
        check("ooo_c1_valid", bus.validCommit, 1);
        check("ooo_c1_rob", bus.commitROB, 1);
        check("ooo_c1_reg", bus.regCommit, 2);
        check("ooo_c1_value", bus.commitValue, 32'h11);
        tick();
        check("ooo_c2_rob", bus.commitROB, 2);
        check("ooo_c2_reg", bus.regCommit, 3);
        check("ooo_c2_value", bus.commitValue, 32'h22);
        tick();
        check("ooo_stall_valid", bus.validCommit, 0);
        check("ooo_stall_rob", bus.commitROB, 3);

        // head=3 tail=0 count=5; retire tag 3 to reach count=4
        cdb(3'd3, 32'h33);
        tick();
        cdb(3'd4, 32'h44);
        check("c3_rob", bus.commitROB, 3);
        check("c3_reg", bus.regCommit, 4);
        tick();
        // count=4: allocate and commit together
        idle();
        bus.allocValid    = 1'b1;
        bus.allocDestReg  = 5'd10;
        bus.allocRegWrite = 1'b0;
        check("ac_valid", bus.validCommit, 1);
        check("ac_rob", bus.commitROB, 4);
        check("ac_destROB", bus.destROB, 0);
        tick();
        idle();
        check("ac_tail_adv", bus.destROB, 1);
        check("ac_head_adv", bus.commitROB, 5);
        check("ac_no_commit", bus.validCommit, 0);

        // Drain entries 5,6,7,0 to confirm count stayed 4
        cdb(3'd5, 32'h55);
        tick();
        cdb(3'd6, 32'h66);
        check("dr_c5_rob", bus.commitROB, 5);
        tick();
        cdb(3'd7, 32'h77);
        check("dr_c6_value", bus.commitValue, 32'h66);
        tick();
        cdb(3'd0, 32'hA0);
        check("dr_c7_rob", bus.commitROB, 7);
        check("dr_c7_empty", bus.empty, 0);
        tick();
        idle();
        check("dr_c0_valid", bus.validCommit, 1);
        check("dr_c0_rob", bus.commitROB, 0);
        check("dr_c0_reg", bus.regCommit, 10);
        check("dr_c0_noregwrite", bus.commitRegWrite, 0);
        check("dr_c0_value", bus.commitValue, 32'hA0);
        check("dr_c0_notempty", bus.empty, 0);
        tick();
        check("dr_empty", bus.empty, 1);
        check("dr_destROB", bus.destROB, 1);
        // CDB to an unallocated tag while empty
        cdb(3'd1, 32'hEE);
        tick();
        idle();
        check("empty_cdb_no_commit", bus.validCommit, 0);
        check("empty_cdb_empty", bus.empty, 1);

        // Walk pointers to 6 with single alloc/writeback/commit triples
        for (int k = 1; k < 6; k++) begin
            bus.allocValid    = 1'b1;
            bus.allocDestReg  = 5'(k);
            bus.allocRegWrite = 1'b1;
            check($sformatf("walk_destROB_%0d", k), bus.destROB, 32'(k));
            tick();
            idle();
            cdb(3'(k), 32'(k));
            tick();
            idle();
            check($sformatf("walk_commit_%0d", k), bus.commitROB, 32'(k));
            tick();
        end
        check("walk_empty", bus.empty, 1);
        check("walk_destROB", bus.destROB, 6);

        // Wrap: allocate 4 -> tags 6,7,0,1
        for (int k = 0; k < 4; k++) begin
            bus.allocValid    = 1'b1;
            bus.allocDestReg  = 5'(20 + k);
            bus.allocRegWrite = 1'b1;
            check($sformatf("wrap_destROB_%0d", k), bus.destROB, 32'((6 + k) % 8));
            tick();
        end
        idle();
        cdb(3'd6, 32'h606);
        tick();
        cdb(3'd7, 32'h707);
        check("wrap_c6", bus.commitROB, 6);
        tick();
        cdb(3'd0, 32'h0A0);
        check("wrap_c7", bus.commitROB, 7);
        tick();
        cdb(3'd1, 32'h1A1);
        check("wrap_c0", bus.commitROB, 0);
        check("wrap_c0_reg", bus.regCommit, 22);
        tick();
        idle();
        check("wrap_c1", bus.commitROB, 1);
        check("wrap_c1_value", bus.commitValue, 32'h1A1);
        check("wrap_c1_valid", bus.validCommit, 1);
        tick();
        check("wrap_empty", bus.empty, 1);

        // Mispredict flush from a fresh buffer with tags 0..3
        globalReset = 1'b0;
        tick();
        globalReset = 1'b1;
        for (int k = 0; k < 4; k++) begin
            bus.allocValid    = 1'b1;
            bus.allocDestReg  = 5'(k + 1);
            bus.allocRegWrite = 1'b1;
            tick();
        end
        idle();
        check("mp_destROB", bus.destROB, 4);
        bus.cdbValid      = 1'b1;
        bus.cdbROB        = 3'd0;
        bus.cdbResult     = 32'h5;
        bus.cdbMispredict = 1'b1;
        bus.cdbTarget     = 32'h100;
        tick();
        idle();
        bus.allocValid    = 1'b1;
        bus.allocDestReg  = 5'd7;
        bus.allocRegWrite = 1'b1;
        cdb(3'd2, 32'h99);
        check("mp_valid", bus.validCommit, 1);
        check("mp_reset", bus.reset, 1);
        check("mp_redirect", bus.redirectPC, 32'h100);
        check("mp_rob", bus.commitROB, 0);
        tick();
        idle();
        check("mp_empty", bus.empty, 1);
        check("mp_destROB_after", bus.destROB, 0);
        check("mp_no_commit", bus.validCommit, 0);
        check("mp_reset_low", bus.reset, 0);

        // Reset asserted during a flush cycle wins and clears entry contents
        bus.allocValid    = 1'b1;
        bus.allocDestReg  = 5'd3;
        bus.allocRegWrite = 1'b1;
        tick();
        idle();
        bus.cdbValid      = 1'b1;
        bus.cdbROB        = 3'd0;
        bus.cdbResult     = 32'h77;
        bus.cdbMispredict = 1'b1;
        bus.cdbTarget     = 32'h200;
        tick();
        idle();
        check("rmf_flushing", bus.reset, 1);
        check("rmf_redirect", bus.redirectPC, 32'h200);
        bus.allocValid    = 1'b1;
        bus.allocDestReg  = 5'd9;
        globalReset       = 1'b0;
        tick();
        globalReset = 1'b1;
        idle();
        check("rmf_empty", bus.empty, 1);
        check("rmf_destROB", bus.destROB, 0);
        check("rmf_regCommit", bus.regCommit, 0);
        check("rmf_commitValue", bus.commitValue, 0);
        check("rmf_redirectPC", bus.redirectPC, 0);
        check("rmf_no_commit", bus.validCommit, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
